// File: rtl/cache_wait_pkg.sv
// Shared types and default sizing for the cache wait-state controller.
package cache_wait_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } wait_state_e;

    localparam int CACHE_WAIT_NUM_CH = 2;
    localparam int CACHE_WAIT_CNT_W  = 4;

endpackage

// File: rtl/cache_wait_ch.sv
// One wait channel: load a count on start, count down to zero, then hold
// ready until acknowledged. Abort returns the channel to IDLE from anywhere.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no access outstanding, count held at 0
//   WAIT  | counting down the programmed wait (frozen while stall_i=1)
//   DONE  | wait complete, ready_o=1 until ack_i; ack+start reloads
module cache_wait_ch
    import cache_wait_pkg::*;
#(
    parameter int CNT_W = CACHE_WAIT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             ack_i,
    input  logic             abort_i,
    input  logic             stall_i,
    output logic             ready_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wait_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d   = load_value_i;
                    state_d = (load_value_i == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!stall_i) begin
                    // Count of 0 cannot occur here, but finish cleanly rather than wrap.
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            DONE: begin
                cnt_d = '0;
                if (ack_i) begin
                    if (start_i) begin
                        cnt_d   = load_value_i;
                        state_d = (load_value_i == '0) ? DONE : WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign ready_o = (state_q == DONE);
    assign count_o = cnt_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: rtl/cache_wait_ctrl.sv
// Multi-channel wait-state controller: NUM_CH independent cache_wait_ch
// instances on sliced buses, with a combined busy flag.
// Optional feature macro: WAIT_STALL_EN adds the per-channel stall_i port
// that freezes a channel's countdown while it is waiting.
module cache_wait_ctrl
    import cache_wait_pkg::*;
#(
    parameter int NUM_CH = CACHE_WAIT_NUM_CH,
    parameter int CNT_W  = CACHE_WAIT_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH*CNT_W-1:0] load_value_i,
    input  logic [NUM_CH-1:0]       ack_i,
    input  logic [NUM_CH-1:0]       abort_i,
`ifdef WAIT_STALL_EN
    input  logic [NUM_CH-1:0]       stall_i,
`endif
    output logic [NUM_CH-1:0]       ready_o,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic                    busy_o
);

    logic [NUM_CH-1:0] stall_w;
    logic [NUM_CH-1:0] busy_w;

`ifdef WAIT_STALL_EN
    assign stall_w = stall_i;
`else
    assign stall_w = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cache_wait_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .start_i      (start_i[g]),
            .load_value_i (load_value_i[g*CNT_W +: CNT_W]),
            .ack_i        (ack_i[g]),
            .abort_i      (abort_i[g]),
            .stall_i      (stall_w[g]),
            .ready_o      (ready_o[g]),
            .count_o      (count_o[g*CNT_W +: CNT_W]),
            .busy_o       (busy_w[g])
        );
    end

    assign busy_o = |busy_w;

endmodule

// File: tb/tb_cache_wait_ctrl.sv
// Bench for cache_wait_ctrl: directed scenarios plus randomized traffic
// against a deadline-based reference model.
module tb_cache_wait_ctrl;
    import cache_wait_pkg::*;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;
`ifdef WAIT_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NUM_CH-1:0]       start_i, ack_i, abort_i, stall_i;
    logic [NUM_CH*CNT_W-1:0] load_value_i;
    logic [NUM_CH-1:0]       ready_o;
    logic [NUM_CH*CNT_W-1:0] count_o;
    logic                    busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: an active channel becomes ready at edge m_deadline; count is the
    // number of edges still to go.
    bit m_active   [NUM_CH];
    int m_deadline [NUM_CH];

    always #5 clk_i = ~clk_i;

    cache_wait_ctrl #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .load_value_i (load_value_i),
        .ack_i        (ack_i),
        .abort_i      (abort_i),
`ifdef WAIT_STALL_EN
        .stall_i      (stall_i),
`endif
        .ready_o      (ready_o),
        .count_o      (count_o),
        .busy_o       (busy_o)
    );

    function automatic logic [CNT_W-1:0] cnt_of(int c);
        return count_o[c*CNT_W +: CNT_W];
    endfunction

    function automatic logic exp_ready(int c);
        return m_active[c] && (cyc >= m_deadline[c]);
    endfunction

    function automatic logic [CNT_W-1:0] exp_count(int c);
        if (m_active[c] && cyc < m_deadline[c]) return CNT_W'(m_deadline[c] - cyc);
        return '0;
    endfunction

    function automatic logic exp_busy();
        logic b = 1'b0;
        for (int c = 0; c < NUM_CH; c++) b |= m_active[c];
        return b;
    endfunction

    task automatic set_load(int c, int v);
        load_value_i[c*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic idle_inputs();
        rst_i        = 1'b0;
        start_i      = '0;
        ack_i        = '0;
        abort_i      = '0;
        stall_i      = '0;
        load_value_i = '0;
    endtask

    // Advance one edge, update the model from the inputs sampled there, and
    // return 1 time unit later so outputs are stable for checking.
    task automatic clock_edge();
        logic [CNT_W-1:0] lv;
        bit               was_wait;
        @(posedge clk_i);
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            lv       = load_value_i[c*CNT_W +: CNT_W];
            was_wait = m_active[c] && ((cyc - 1) < m_deadline[c]);
            if (rst_i || abort_i[c]) begin
                m_active[c] = 1'b0;
            end else if (!m_active[c]) begin
                if (start_i[c]) begin
                    m_active[c]   = 1'b1;
                    m_deadline[c] = cyc + int'(lv);
                end
            end else if (!was_wait) begin
                if (ack_i[c]) begin
                    if (start_i[c]) m_deadline[c] = cyc + int'(lv);
                    else            m_active[c]   = 1'b0;
                end
            end else if (STALL_EN && stall_i[c]) begin
                m_deadline[c]++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i   = 1'b1;
        start_i = '1;
        load_value_i = NUM_CH*CNT_W'($urandom);
        clock_edge();
        idle_inputs();
        n_cmp++;
        if (ready_o !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        n_cmp++;
        if (count_o !== '0) begin n_err++; $display("FAIL reset_count: got %h want 0", count_o); end
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_latency();
        idle_inputs();
        start_i[0] = 1'b1;
        set_load(0, 3);
        clock_edge();
        idle_inputs();
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) clock_edge();
            n_cmp++;
            if (cnt_of(0) !== CNT_W'(3 - i)) begin
                n_err++; $display("FAIL lat_count step %0d: got %0d want %0d", i, cnt_of(0), 3 - i);
            end
            n_cmp++;
            if (ready_o[0] !== (i == 3)) begin
                n_err++; $display("FAIL lat_ready step %0d: got %b want %b", i, ready_o[0], (i == 3));
            end
        end
        for (int i = 0; i < 5; i++) begin
            clock_edge();
            n_cmp++;
            if (ready_o[0] !== 1'b1) begin n_err++; $display("FAIL lat_hold %0d: got %b want 1", i, ready_o[0]); end
        end
        ack_i[0] = 1'b1;
        clock_edge();
        idle_inputs();
        n_cmp++;
        if (ready_o[0] !== 1'b0) begin n_err++; $display("FAIL lat_ack_ready: got %b want 0", ready_o[0]); end
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL lat_ack_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_two_channels();
        idle_inputs();
        start_i[0] = 1'b1;
        set_load(0, 15);
        clock_edge();
        idle_inputs();
        clock_edge();
        clock_edge();
        start_i[1] = 1'b1;
        set_load(1, 0);
        clock_edge();
        idle_inputs();
        n_cmp++;
        if (ready_o !== 2'b10) begin n_err++; $display("FAIL two_ready_l0: got %b want 10", ready_o); end
        n_cmp++;
        if (cnt_of(0) !== CNT_W'(12)) begin n_err++; $display("FAIL two_ch0_count: got %0d want 12", cnt_of(0)); end
        ack_i[1] = 1'b1;
        clock_edge();
        idle_inputs();
        for (int i = 0; i < 11; i++) begin
            n_cmp++;
            if (busy_o !== 1'b1 || ready_o !== 2'b00) begin
                n_err++; $display("FAIL two_busy step %0d: got busy %b ready %b want busy 1 ready 00", i, busy_o, ready_o);
            end
            clock_edge();
        end
        n_cmp++;
        if (ready_o !== 2'b01) begin n_err++; $display("FAIL two_ready_l15: got %b want 01", ready_o); end
        ack_i[0] = 1'b1;
        clock_edge();
        idle_inputs();
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL two_final_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        start_i[1] = 1'b1;
        set_load(1, 1);
        clock_edge();
        idle_inputs();
        clock_edge();
        n_cmp++;
        if (ready_o[1] !== 1'b1) begin n_err++; $display("FAIL b2b_first_ready: got %b want 1", ready_o[1]); end
        ack_i[1]   = 1'b1;
        start_i[1] = 1'b1;
        set_load(1, 2);
        clock_edge();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) clock_edge();
            n_cmp++;
            if (ready_o[1] !== (i == 2) || cnt_of(1) !== CNT_W'(2 - i) || busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_step %0d: got ready %b count %0d busy %b want ready %b count %0d busy 1",
                         i, ready_o[1], cnt_of(1), busy_o, (i == 2), 2 - i);
            end
        end
        ack_i[1] = 1'b1;
        clock_edge();
        idle_inputs();
    endtask

    task automatic test_abort();
        idle_inputs();
        start_i[0] = 1'b1;
        set_load(0, 9);
        clock_edge();
        idle_inputs();
        repeat (4) clock_edge();
        n_cmp++;
        if (cnt_of(0) !== CNT_W'(5)) begin n_err++; $display("FAIL abort_pre_count: got %0d want 5", cnt_of(0)); end
        abort_i[0] = 1'b1;
        start_i[0] = 1'b1;
        ack_i[0]   = 1'b1;
        set_load(0, 6);
        clock_edge();
        idle_inputs();
        n_cmp++;
        if (cnt_of(0) !== '0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: got count %0d busy %b want 0 0", cnt_of(0), busy_o);
        end
        for (int i = 0; i < 8; i++) begin
            clock_edge();
            n_cmp++;
            if (ready_o[0] !== 1'b0) begin n_err++; $display("FAIL abort_no_ready %0d: got %b want 0", i, ready_o[0]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        start_i[0] = 1'b1;
        set_load(0, 10);
        start_i[1] = 1'b1;
        set_load(1, 0);
        clock_edge();
        idle_inputs();
        repeat (3) clock_edge();
        n_cmp++;
        if (cnt_of(0) !== CNT_W'(7) || ready_o[1] !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: got count %0d ready1 %b want 7 1", cnt_of(0), ready_o[1]);
        end
        rst_i   = 1'b1;
        ack_i   = '1;
        start_i = '1;
        set_load(0, 5);
        clock_edge();
        idle_inputs();
        n_cmp++;
        if (ready_o !== '0 || count_o !== '0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs: got ready %b count %h busy %b want 0 0 0", ready_o, count_o, busy_o);
        end
    endtask

`ifdef WAIT_STALL_EN
    task automatic test_stall();
        idle_inputs();
        start_i[0] = 1'b1;
        set_load(0, 4);
        clock_edge();
        idle_inputs();
        for (int i = 1; i <= 7; i++) begin
            stall_i[0] = (i <= 3);
            clock_edge();
            n_cmp++;
            if (ready_o[0] !== (i == 7)) begin
                n_err++; $display("FAIL stall_ready edge k+%0d: got %b want %b", i, ready_o[0], (i == 7));
            end
        end
        idle_inputs();
        ack_i[0] = 1'b1;
        clock_edge();
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                start_i[c] = ($urandom_range(0, 2) == 0);
                ack_i[c]   = ($urandom_range(0, 1) == 0);
                abort_i[c] = ($urandom_range(0, 19) == 0);
                stall_i[c] = ($urandom_range(0, 3) == 0);
                set_load(c, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15)));
            end
            clock_edge();
            for (int c = 0; c < NUM_CH; c++) begin
                n_cmp++;
                if (ready_o[c] !== exp_ready(c)) begin
                    n_err++; $display("FAIL rand_ready ch%0d cyc %0d: got %b want %b", c, cyc, ready_o[c], exp_ready(c));
                end
                n_cmp++;
                if (cnt_of(c) !== exp_count(c)) begin
                    n_err++; $display("FAIL rand_count ch%0d cyc %0d: got %0d want %0d", c, cyc, cnt_of(c), exp_count(c));
                end
            end
            n_cmp++;
            if (busy_o !== exp_busy()) begin
                n_err++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, busy_o, exp_busy());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_latency();
        test_two_channels();
        test_back_to_back();
        test_abort();
        test_reset_mid_wait();
`ifdef WAIT_STALL_EN
        test_stall();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
